// File: rtl/maze_ni_pkg.sv
// Shared types and helpers for the mesh network-interface injection stage.
// Contents:
//   pkt_t       - packed packet {ptype, qos, src, tgt, data}, PKT_W bits
//   node_id()   - builds a 6-bit node ID {x[2:0], y[2:0]} from coordinates
package maze_ni_pkg;

    localparam int PKT_W     = 23;
    localparam int NODE_ID_W = 6;
    localparam int COORD_W   = 3;

    localparam logic [1:0] TYPE_UNICAST = 2'b00;

    typedef struct packed {
        logic [1:0]           ptype;
        logic                 qos;
        logic [NODE_ID_W-1:0] src;
        logic [NODE_ID_W-1:0] tgt;
        logic [7:0]           data;
    } pkt_t;

    function automatic logic [NODE_ID_W-1:0] node_id(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// Single-clock FIFO used for the per-QoS injection queues.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset (flushes pointers/level)
//   push_i, wdata_i - write request and data; ignored while full, even if a
//                     pop happens in the same cycle (no write-through)
//   pop_i, rdata_o  - read request; rdata_o shows the head entry whenever non-empty
//   full_o, empty_o - status flags
//   level_o         - occupancy, 0..DEPTH inclusive
module ni_sync_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage needs no reset: entries are only observed once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/node_inject_ni.sv
// Local NI injection stage feeding the mesh node's local input port.
// Host packets are source-stamped with this node's ID, filtered against the
// power-gated node, queued per QoS class, and arbitrated (high over low, with
// a starvation limit) into a single registered valid/ready output.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   pg_en, pg_node             - power-gating enable and gated node ID
//   host_vld/type/qos/tgt/data - host packet in; host_rdy accepts (vld && rdy)
//   pkt_in_*                   - registered packet out, pkt_in_rdy from node
//   drop_pulse, drop_cnt       - per-drop pulse and saturating drop count
//   lvl_hi, lvl_lo             - per-QoS FIFO occupancy
// Handshake: a transfer happens on an edge where valid && ready; while
// valid && !ready the sender holds every field stable.
module node_inject_ni
    import maze_ni_pkg::*;
#(
    parameter int HP         = 0,
    parameter int VP         = 0,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pg_en,
    input  logic [5:0]             pg_node,
    input  logic                   host_vld,
    input  logic [1:0]             host_type,
    input  logic                   host_qos,
    input  logic [5:0]             host_tgt,
    input  logic [7:0]             host_data,
    output logic                   host_rdy,
    output logic                   pkt_in_vld,
    output logic [1:0]             pkt_in_type,
    output logic                   pkt_in_qos,
    output logic [5:0]             pkt_in_src,
    output logic [5:0]             pkt_in_tgt,
    output logic [7:0]             pkt_in_data,
    input  logic                   pkt_in_rdy,
    output logic                   drop_pulse,
    output logic [7:0]             drop_cnt,
    output logic [$clog2(DEPTH):0] lvl_hi,
    output logic [$clog2(DEPTH):0] lvl_lo
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [NODE_ID_W-1:0] SRC_ID = node_id(COORD_W'(HP), COORD_W'(VP));

    pkt_t          host_pkt, hi_head, lo_head;
    pkt_t          out_q;
    logic          vld_q;
    logic          drop_pulse_q;
    logic [7:0]    drop_cnt_q;
    logic [SW-1:0] starve_q, starve_d;

    logic drop_match, drop_ev;
    logic push_hi, push_lo;
    logic full_hi, full_lo, empty_hi, empty_lo;
    logic load, pick_hi, pop_hi, pop_lo;

    // ---------------- drop filter / accept ----------------
    // Gated-target packets are always taken (and discarded) so the host never
    // stalls on a dead destination.
    assign drop_match = pg_en && (host_tgt == pg_node);
    assign drop_ev    = host_vld && drop_match;
    assign host_rdy   = drop_match || (host_qos ? !full_hi : !full_lo);
    assign push_hi    = host_vld && !drop_match && host_qos;
    assign push_lo    = host_vld && !drop_match && !host_qos;

    always_comb begin
        host_pkt       = '0;
        host_pkt.ptype = host_type;
        host_pkt.qos   = host_qos;
        host_pkt.src   = SRC_ID;
        host_pkt.tgt   = host_tgt;
        host_pkt.data  = host_data;
    end

    ni_sync_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_fifo_hi (
        .clk(clk), .rst_n(rst_n),
        .push_i(push_hi), .wdata_i(host_pkt),
        .pop_i(pop_hi), .rdata_o(hi_head),
        .full_o(full_hi), .empty_o(empty_hi), .level_o(lvl_hi)
    );

    ni_sync_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_fifo_lo (
        .clk(clk), .rst_n(rst_n),
        .push_i(push_lo), .wdata_i(host_pkt),
        .pop_i(pop_lo), .rdata_o(lo_head),
        .full_o(full_lo), .empty_o(empty_lo), .level_o(lvl_lo)
    );

    // ---------------- arbiter ----------------
    always_comb begin
        load     = (!vld_q || pkt_in_rdy) && (!empty_hi || !empty_lo);
        pick_hi  = !empty_hi && (empty_lo || (starve_q < SW'(STARVE_MAX)));
        pop_hi   = load && pick_hi;
        pop_lo   = load && !pick_hi;
        starve_d = starve_q;
        // The count only measures how long a waiting low packet was bypassed.
        if (empty_lo || pop_lo) begin
            starve_d = '0;
        end else if (pop_hi && (starve_q < SW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // ---------------- output register and drop stats ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q        <= 1'b0;
            out_q        <= '0;
            starve_q     <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            starve_q     <= starve_d;
            drop_pulse_q <= drop_ev;
            if (drop_ev && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
            if (load) begin
                vld_q <= 1'b1;
                out_q <= pick_hi ? hi_head : lo_head;
            end else if (pkt_in_rdy) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign pkt_in_vld  = vld_q;
    assign pkt_in_type = out_q.ptype;
    assign pkt_in_qos  = out_q.qos;
    assign pkt_in_src  = out_q.src;
    assign pkt_in_tgt  = out_q.tgt;
    assign pkt_in_data = out_q.data;
    assign drop_pulse  = drop_pulse_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_node_inject_ni.sv
module tb_node_inject_ni;
  import maze_ni_pkg::*;

  localparam int DEPTH  = 4;
  localparam int SMAX   = 2;
  localparam int MY_ID  = 3 * 8 + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       pg_en = 1'b0;
  logic [5:0] pg_node = 6'd12;
  logic       host_vld = 1'b0;
  logic [1:0] host_type = 2'b00;
  logic       host_qos = 1'b0;
  logic [5:0] host_tgt = '0;
  logic [7:0] host_data = '0;
  logic       host_rdy;
  logic       pkt_in_vld;
  logic [1:0] pkt_in_type;
  logic       pkt_in_qos;
  logic [5:0] pkt_in_src;
  logic [5:0] pkt_in_tgt;
  logic [7:0] pkt_in_data;
  logic       pkt_in_rdy = 1'b0;
  logic       drop_pulse;
  logic [7:0] drop_cnt;
  logic [2:0] lvl_hi, lvl_lo;

  node_inject_ni #(.HP(3), .VP(3), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .pg_en(pg_en), .pg_node(pg_node),
    .host_vld(host_vld), .host_type(host_type), .host_qos(host_qos),
    .host_tgt(host_tgt), .host_data(host_data), .host_rdy(host_rdy),
    .pkt_in_vld(pkt_in_vld), .pkt_in_type(pkt_in_type), .pkt_in_qos(pkt_in_qos),
    .pkt_in_src(pkt_in_src), .pkt_in_tgt(pkt_in_tgt), .pkt_in_data(pkt_in_data),
    .pkt_in_rdy(pkt_in_rdy), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt),
    .lvl_hi(lvl_hi), .lvl_lo(lvl_lo)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [PKT_W-1:0] hi_q[$];
  logic [PKT_W-1:0] lo_q[$];
  logic [PKT_W-1:0] exp_out;
  logic             exp_vld;
  int               starve;
  int               exp_dcnt;
  logic             exp_dpulse;
  logic             last_acc;
  logic             last_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hi_q.delete();
    lo_q.delete();
    exp_out = '0;
    exp_vld = 1'b0;
    starve = 0;
    exp_dcnt = 0;
    exp_dpulse = 1'b0;
  endtask

  function automatic logic model_rdy();
    if (pg_en && host_tgt == pg_node) return 1'b1;
    if (host_qos) return hi_q.size() < DEPTH;
    return lo_q.size() < DEPTH;
  endfunction

  // One clock edge of the reference: pick an output, then enqueue the host packet.
  task automatic model_edge();
    logic drop, acc, hi_ne, lo_ne;
    logic [PKT_W-1:0] p;
    drop  = pg_en && (host_tgt == pg_node);
    acc   = host_vld && model_rdy();
    hi_ne = hi_q.size() > 0;
    lo_ne = lo_q.size() > 0;
    if ((!exp_vld || pkt_in_rdy) && (hi_ne || lo_ne)) begin
      if (hi_ne && (!lo_ne || starve < SMAX)) begin
        exp_out = hi_q.pop_front();
        starve = lo_ne ? ((starve < SMAX) ? starve + 1 : starve) : 0;
      end else begin
        exp_out = lo_q.pop_front();
        starve = 0;
      end
      exp_vld = 1'b1;
    end else begin
      if (pkt_in_rdy) exp_vld = 1'b0;
      if (!lo_ne) starve = 0;
    end
    exp_dpulse = host_vld && drop;
    if (host_vld && drop && exp_dcnt < 255) exp_dcnt++;
    if (acc && !drop) begin
      p = {host_type, host_qos, 6'(MY_ID), host_tgt, host_data};
      if (host_qos) hi_q.push_back(p);
      else lo_q.push_back(p);
    end
  endtask

  task automatic check_outputs();
    chk("pkt_in_vld", pkt_in_vld, exp_vld);
    if (exp_vld)
      chk("pkt_in", {pkt_in_type, pkt_in_qos, pkt_in_src, pkt_in_tgt, pkt_in_data}, exp_out);
    chk("lvl_hi", lvl_hi, hi_q.size());
    chk("lvl_lo", lvl_lo, lo_q.size());
    chk("drop_pulse", drop_pulse, exp_dpulse);
    chk("drop_cnt", drop_cnt, exp_dcnt);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive, check host_rdy, advance one edge, check outputs.
  task automatic step(input logic vld, input logic qos, input logic [5:0] tgt,
                      input logic [7:0] data, input logic rdy);
    host_vld = vld; host_qos = qos; host_tgt = tgt; host_data = data;
    pkt_in_rdy = rdy;
    #1;
    last_rdy = model_rdy();
    chk("host_rdy", host_rdy, last_rdy);
    last_acc = vld && last_rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 8'd0, rdy);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] r_tgt;
    logic [7:0] r_dat;
    logic       r_vld, r_qos;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_host_rdy", host_rdy, 1);
    chk("reset_out", {pkt_in_vld, pkt_in_type, pkt_in_qos, pkt_in_src, pkt_in_tgt, pkt_in_data}, 0);
    chk("reset_stats", {drop_pulse, drop_cnt, lvl_hi, lvl_lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single low packet, two-edge latency
    step(1'b1, 1'b0, 6'd27, 8'hAA, 1'b1);
    chk("t1_not_yet", pkt_in_vld, 0);
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
    chk("t1_src", pkt_in_src, MY_ID);
    chk("t1_data", pkt_in_data, 8'hAA);
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
    chk("t1_vld_fall", pkt_in_vld, 0);

    // 2: backpressure fills register + low FIFO
    for (int d = 0; d < 6; d++) step(1'b1, 1'b0, 6'd9, 8'(d), 1'b0);
    chk("t2_blocked", last_rdy, 0);
    chk("t2_lvl_lo", lvl_lo, DEPTH);
    chk("t2_head", pkt_in_data, 0);
    idle(6, 1'b1);

    // 3: low then high while stalled
    for (int d = 1; d <= 3; d++) step(1'b1, 1'b0, 6'd5, 8'(d), 1'b0);
    for (int d = 0; d < 3; d++) step(1'b1, 1'b1, 6'd5, 8'hA0 + 8'(d), 1'b0);
    idle(8, 1'b1);

    // 4: starvation limit under a continuous high stream
    step(1'b1, 1'b0, 6'd7, 8'h51, 1'b0);
    step(1'b1, 1'b0, 6'd7, 8'h52, 1'b0);
    step(1'b1, 1'b0, 6'd7, 8'h53, 1'b0);
    for (int d = 0; d < 10; d++) step(1'b1, 1'b1, 6'd7, 8'hC0 + 8'(d), 1'b1);
    idle(8, 1'b1);

    // 5: drop filter against full FIFOs, then saturation
    pg_en = 1'b1;
    for (int d = 0; d < 5; d++) step(1'b1, 1'b0, 6'd5, 8'(d), 1'b0);
    for (int d = 0; d < 4; d++) step(1'b1, 1'b1, 6'd5, 8'(d), 1'b0);
    step(1'b1, 1'b0, 6'd12, 8'h77, 1'b0);
    chk("t5_drop_rdy", last_rdy, 1);
    chk("t5_drop_pulse", drop_pulse, 1);
    chk("t5_drop_cnt", drop_cnt, 1);
    step(1'b0, 1'b0, 6'd0, 8'h00, 1'b0);
    chk("t5_pulse_once", drop_pulse, 0);
    idle(10, 1'b1);
    pg_en = 1'b0;
    step(1'b1, 1'b0, 6'd12, 8'h77, 1'b1);
    chk("t5_queued", lvl_lo, 1);
    idle(2, 1'b1);
    pg_en = 1'b1;
    for (int d = 0; d < 300; d++) step(1'b1, d[0], 6'd12, 8'(d), 1'(d % 3 != 0));
    chk("t5_saturate", drop_cnt, 255);
    pg_en = 1'b0;
    idle(3, 1'b1);

    // 6: asynchronous reset with traffic in flight
    for (int d = 0; d < 4; d++) step(1'b1, d[0], 6'd5, 8'(d), 1'b0);
    host_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld_async", pkt_in_vld, 0);
    chk("t6_lvl", {lvl_hi, lvl_lo}, 0);
    chk("t6_dcnt", drop_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 6'd0, 8'd0, 1'b1);
      chk("t6_no_stale", pkt_in_vld, 0);
    end

    // 7: randomized traffic
    r_vld = 1'b0; r_qos = 1'b0; r_tgt = '0; r_dat = '0;
    last_acc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(r_vld && !last_acc)) begin
        r_vld = ($urandom_range(0, 9) < 7);
        r_qos = 1'($urandom_range(0, 1));
        r_tgt = ($urandom_range(0, 4) == 0) ? 6'd12 : 6'($urandom_range(0, 63));
        r_dat = 8'($urandom_range(0, 255));
        host_type = 2'($urandom_range(0, 3));
      end
      if (i % 50 == 0) pg_en = ($urandom_range(0, 3) == 0);
      step(r_vld, r_qos, r_tgt, r_dat, ($urandom_range(0, 9) < 6));
    end
    host_type = TYPE_UNICAST;
    idle(12, 1'b1);
    chk("end_drained", {pkt_in_vld, lvl_hi, lvl_lo}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
